// File: rtl/ela_param.sv
// Parametrised ELA deinterlacer: emits source rows with an edge-directed
// interpolated row between each pair. Optional macro: ELA_WIDE_DIR_EN.
//
// Ports:
//   clk      - clock, all logic on rising edge
//   rst      - synchronous active-high reset
//   start    - frame start pulse, only honoured in IDLE
//   in_data  - source pixel from host, WIDTH bits
//   req      - one-cycle row request to host
//   out_data - registered output pixel, WIDTH bits
//   valid    - out_data qualifier
//   done     - one-cycle pulse after the last pixel of a frame
//
// ELA_WIDE_DIR_EN adds the two +/-2 diagonals on columns 2..COLS-3.
module ela_param #(
  parameter int WIDTH = 8,
  parameter int COLS  = 16,
  parameter int ROWS  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  output logic             req,
  output logic [WIDTH-1:0] out_data,
  output logic             valid,
  output logic             done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_NUM  = RW'(ROWS);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    LOAD,
    OUT_INT,
    OUT_ORG,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             ptr_q, ptr_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Ping-pong line buffers; ptr_q selects the newest row.
  logic [WIDTH-1:0] lb_q [2][COLS];

  function automatic logic [WIDTH-1:0] adiff(
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] q
  );
    return (p > q) ? p - q : q - p;
  endfunction

  function automatic logic [WIDTH-1:0] avg2(
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH:0] s;
    s = {1'b0, p} + {1'b0, q};
    return s[WIDTH:1];
  endfunction

  logic             up;
  logic [CW-1:0]    xm1, xp1;
  logic [WIDTH-1:0] d1, d3, d_best;
  logic [WIDTH-1:0] p_sel, q_sel, interp;
`ifdef ELA_WIDE_DIR_EN
  logic [CW-1:0]    xm2, xp2;
  logic [WIDTH-1:0] d0, d4;
`endif

  // Candidates are compared with strict '<' in priority order so that
  // an earlier direction wins every tie.
  always_comb begin
    up     = ~ptr_q;
    xm1    = (col_q == '0) ? '0 : col_q - CW'(1);
    xp1    = (col_q == COL_LAST) ? COL_LAST
                                 : col_q + CW'(1);
    p_sel  = lb_q[up][col_q];
    q_sel  = lb_q[ptr_q][col_q];
    d_best = adiff(p_sel, q_sel);
    d1     = adiff(lb_q[up][xm1], lb_q[ptr_q][xp1]);
    d3     = adiff(lb_q[up][xp1], lb_q[ptr_q][xm1]);
`ifdef ELA_WIDE_DIR_EN
    xm2    = (col_q < CW'(2)) ? '0 : col_q - CW'(2);
    xp2    = (col_q > COL_LAST - CW'(2)) ? COL_LAST
                                         : col_q + CW'(2);
    d0     = adiff(lb_q[up][xm2], lb_q[ptr_q][xp2]);
    d4     = adiff(lb_q[up][xp2], lb_q[ptr_q][xm2]);
`endif
    if (col_q != '0 && col_q != COL_LAST) begin
      if (d1 < d_best) begin
        d_best = d1;
        p_sel  = lb_q[up][xm1];
        q_sel  = lb_q[ptr_q][xp1];
      end
      if (d3 < d_best) begin
        d_best = d3;
        p_sel  = lb_q[up][xp1];
        q_sel  = lb_q[ptr_q][xm1];
      end
`ifdef ELA_WIDE_DIR_EN
      if (col_q >= CW'(2) &&
          col_q <= COL_LAST - CW'(2)) begin
        if (d0 < d_best) begin
          d_best = d0;
          p_sel  = lb_q[up][xm2];
          q_sel  = lb_q[ptr_q][xp2];
        end
        if (d4 < d_best) begin
          d_best = d4;
          p_sel  = lb_q[up][xp2];
          q_sel  = lb_q[ptr_q][xm2];
        end
      end
`endif
    end
    interp = avg2(p_sel, q_sel);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          col_d   = '0;
          row_d   = '0;
          ptr_d   = 1'b0;
        end
      end
      REQ: begin
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        col_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        col_d = col_q + CW'(1);
        if (col_q == COL_LAST) begin
          col_d   = '0;
          row_d   = row_q + RW'(1);
          state_d = (row_q == '0) ? OUT_ORG : OUT_INT;
        end
      end
      OUT_INT: begin
        valid_d = 1'b1;
        out_d   = interp;
        col_d   = col_q + CW'(1);
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = OUT_ORG;
        end
      end
      OUT_ORG: begin
        valid_d = 1'b1;
        out_d   = lb_q[ptr_q][col_q];
        col_d   = col_q + CW'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q < ROW_NUM) begin
            state_d = REQ;
            ptr_d   = ~ptr_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ptr_q   <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == LOAD) begin
      lb_q[ptr_q][col_q] <= in_data;
    end
  end

  assign req      = req_q;
  assign valid    = valid_q;
  assign done     = done_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_ela_param.sv
// Directed bench for ela_param: default geometry plus a
// WIDTH=10 / COLS=8 / ROWS=3 instance.
module tb_ela_param;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic clr0   = 1'b0;
  logic clr1   = 1'b0;
  logic [7:0] in0;
  logic [9:0] in1;
  logic       req0, valid0, done0;
  logic       req1, valid1, done1;
  logic [7:0] out0;
  logic [9:0] out1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

`ifdef ELA_WIDE_DIR_EN
  localparam logic [9:0] EXP_C3 = 10'h3FF;
`else
  localparam logic [9:0] EXP_C3 = 10'h1FF;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ela_param u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .in_data(in0), .req(req0), .out_data(out0),
    .valid(valid0), .done(done0)
  );

  ela_param #(.WIDTH(10), .COLS(8), .ROWS(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .in_data(in1), .req(req1), .out_data(out1),
    .valid(valid1), .done(done1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] src0(
    input int p, input int r, input int c
  );
    case (p)
      0:       return (r % 2 == 1) ? 8'h30 : 8'h10;
      1:       return (c >= ((r % 2 == 0) ? 8 : 6))
                      ? 8'hFF : 8'h00;
      default: return (r % 2 == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic logic [9:0] src1(input int r, input int c);
    return (c >= ((r % 2 == 0) ? 5 : 1)) ? 10'h3FF : 10'h000;
  endfunction

  // Host model for instance 0
  int pat0 = 0;
  int h0k = -1, h0row = 0;
  int req0_n = 0, val0_n = 0, done0_n = 0, ovl0_n = 0;
  int last_smp0 = 0, first_val0 = 0;
  logic [7:0] cap0 [144];

  always @(negedge clk) begin
    if (rst || clr0) begin
      h0k = -1;
      in0 = 8'hA5;
      if (clr0) begin
        req0_n = 0; val0_n = 0; done0_n = 0; ovl0_n = 0;
      end
    end else begin
      if (req0) begin
        h0row = req0_n;
        req0_n++;
        h0k = 0;
        in0 = 8'hA5;
      end else if (h0k >= 0 && h0k < 16) begin
        in0 = src0(pat0, h0row, h0k);
        if (h0row == 0 && h0k == 15) last_smp0 = cyc + 1;
        h0k++;
      end else begin
        in0 = 8'hA5;
        h0k = -1;
      end
      if (valid0) begin
        if (val0_n < 144) cap0[val0_n] = out0;
        if (val0_n == 0) first_val0 = cyc;
        val0_n++;
      end
      if (valid0 && req0) ovl0_n++;
      if (done0) done0_n++;
    end
  end

  // Host model for instance 1
  int h1k = -1, h1row = 0;
  int req1_n = 0, val1_n = 0, done1_n = 0;
  logic [9:0] cap1 [40];

  always @(negedge clk) begin
    if (rst || clr1) begin
      h1k = -1;
      in1 = 10'h155;
      if (clr1) begin
        req1_n = 0; val1_n = 0; done1_n = 0;
      end
    end else begin
      if (req1) begin
        h1row = req1_n;
        req1_n++;
        h1k = 0;
        in1 = 10'h155;
      end else if (h1k >= 0 && h1k < 8) begin
        in1 = src1(h1row, h1k);
        h1k++;
      end else begin
        in1 = 10'h155;
        h1k = -1;
      end
      if (valid1) begin
        if (val1_n < 40) cap1[val1_n] = out1;
        val1_n++;
      end
      if (done1) done1_n++;
    end
  end

  task automatic run0(input int p, input bit poke);
    pat0 = p;
    clr0 = 1'b1; tick; clr0 = 1'b0;
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done0_n != 0) break;
      start0 = poke && (i == 40);
      tick;
    end
    start0 = 1'b0;
    repeat (6) tick;
    check("f0_done", done0_n, 1);
    check("f0_valid_cnt", val0_n, 144);
    check("f0_req_cnt", req0_n, 5);
    check("f0_req_valid_ovl", ovl0_n, 0);
  endtask

  task automatic check_flat;
    int err;
    err = 0;
    for (int i = 0; i < 144; i++) begin
      int r, c;
      logic [7:0] e;
      r = i / 16;
      c = i % 16;
      e = (r % 2 == 0) ? src0(0, r / 2, c) : 8'h20;
      if (cap0[i] !== e) err++;
      check($sformatf("flat_px%0d", i), 32'(cap0[i]), 32'(e));
    end
  endtask

  initial begin
    repeat (3) tick;
    check("rst_req", 32'(req0), 0);
    check("rst_valid", 32'(valid0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_out", 32'(out0), 0);
    rst = 1'b0;
    tick;

    run0(0, 1'b1);
    check_flat();
    check("first_valid_lat", first_val0 - last_smp0, 1);

    run0(1, 1'b0);
    check("diag_c7_d3", 32'(cap0[16 + 7]), 32'h00FF);
    check("diag_c0", 32'(cap0[16 + 0]), 32'h0000);
    check("diag_c15", 32'(cap0[16 + 15]), 32'h00FF);
    check("diag_c6", 32'(cap0[16 + 6]), 32'h0000);
    check("diag_org1_c6", 32'(cap0[32 + 6]), 32'h00FF);
    check("diag_r3_c7_d1", 32'(cap0[48 + 7]), 32'h00FF);

    run0(2, 1'b0);
    for (int r = 1; r < 9; r += 2) begin
      for (int c = 0; c < 16; c++) begin
        check($sformatf("tie_r%0d_c%0d", r, c),
              32'(cap0[r * 16 + c]), 32'h007F);
      end
    end
    check("tie_org0", 32'(cap0[0]), 32'h00FF);
    check("tie_org1", 32'(cap0[32]), 32'h0000);

    pat0 = 0;
    clr0 = 1'b1; tick; clr0 = 1'b0;
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (req0_n == 3 && h0k >= 4) break;
      tick;
    end
    check("mid_reach_load3", 32'(req0_n == 3 && h0k >= 4), 1);
    rst = 1'b1;
    tick;
    check("mid_rst_req", 32'(req0), 0);
    check("mid_rst_valid", 32'(valid0), 0);
    check("mid_rst_out", 32'(out0), 0);
    check("mid_rst_done", 32'(done0), 0);
    rst = 1'b0;
    tick;
    run0(0, 1'b0);
    check_flat();

    clr1 = 1'b1; tick; clr1 = 1'b0;
    start1 = 1'b1; tick; start1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done1_n != 0) break;
      tick;
    end
    repeat (6) tick;
    check("w_done", done1_n, 1);
    check("w_valid_cnt", val1_n, 40);
    check("w_req_cnt", req1_n, 3);
    check("w_r1_c3", 32'(cap1[8 + 3]), 32'(EXP_C3));
    check("w_r3_c3", 32'(cap1[24 + 3]), 32'(EXP_C3));
    check("w_r1_c0", 32'(cap1[8 + 0]), 32'h000);
    check("w_r1_c1", 32'(cap1[8 + 1]), 32'h000);
    check("w_r1_c4", 32'(cap1[8 + 4]), 32'h3FF);
    check("w_r1_c7", 32'(cap1[8 + 7]), 32'h3FF);
    check("w_org0_c5", 32'(cap1[5]), 32'h3FF);
    check("w_org2_c4", 32'(cap1[32 + 4]), 32'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
